// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and memory-side signals of the data-memory port arbiter.
// Latency: none (wires only).
// Backpressure: cpu_stall and dbg_ack tell each requester when its access has completed.
// Ports: the slave modport is the arbiter's view and the master modport is the environment's view.
// Groups: cpu_* (memory stage), dbg_* (debug/loader), mem_* (DataMemory / MMIO port).
interface dmem_arbiter_if #(
  parameter int unsigned DBITS = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [DBITS-1:0] cpu_addr;
  logic [DBITS-1:0] cpu_wdata;
  logic [DBITS-1:0] cpu_rdata;
  logic             cpu_stall;

  logic             dbg_req;
  logic             dbg_we;
  logic [DBITS-1:0] dbg_addr;
  logic [DBITS-1:0] dbg_wdata;
  logic [DBITS-1:0] dbg_rdata;
  logic             dbg_ack;

  logic             mem_en;
  logic             mem_we;
  logic [DBITS-1:0] mem_addr;
  logic [DBITS-1:0] mem_wdata;
  logic [DBITS-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory/MMIO port between the CPU memory stage and a debug port.
// Latency: RAM access 2 cycles (IDLE grant + ACCESS); I/O access 2+IO_WAIT cycles.
// Backpressure: cpu_stall holds the pipeline until CPU done; debug waits for the one-cycle dbg_ack.
// Ports: clk, reset (async, active-low), bus (dmem_arbiter_if.slave).
// Optional macro DMEM_ARB_PERF_EN adds perf_stall_cycles[31:0] and perf_dbg_grants[15:0] outputs.
module dmem_arbiter #(
  parameter int unsigned      DBITS        = 32,
  parameter logic [DBITS-1:0] IO_BASE      = 32'hF0000000,
  parameter int unsigned      IO_WAIT      = 2,
  parameter int unsigned      STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_dbg_grants
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_IOWAIT = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] WAIT_LOAD  = 4'(IO_WAIT);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [3:0]       starve_q, starve_d;
  logic [3:0]       wait_q, wait_d;
  logic             we_q, we_d;
  logic [DBITS-1:0] addr_q, addr_d;
  logic [DBITS-1:0] wdata_q, wdata_d;
  logic [DBITS-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DBITS-1:0] dbg_rdata_q, dbg_rdata_d;

  logic grant_dbg, grant_cpu;
  logic done, cpu_done, dbg_done, cpu_stall;

  // Debug wins when the CPU is silent, or when it has lost STARVE_LIMIT IDLE rounds in a row.
  assign grant_dbg = bus.dbg_req & (~bus.cpu_req | (starve_q == STARVE_MAX));
  assign grant_cpu = bus.cpu_req & ~grant_dbg;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_dbg) begin
          owner_d  = OWN_DBG;
          we_d     = bus.dbg_we;
          addr_d   = bus.dbg_addr;
          wdata_d  = bus.dbg_wdata;
          starve_d = 4'd0;
          state_d  = ST_ACCESS;
        end else if (grant_cpu) begin
          owner_d = OWN_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          // Only a win over a waiting debug request counts as debug starvation.
          if (bus.dbg_req && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if ((addr_q < IO_BASE) || (IO_WAIT == 0)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d  = WAIT_LOAD;
          state_d = ST_IOWAIT;
        end
      end
      ST_IOWAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_done = done & (owner_q == OWN_CPU);
  assign dbg_done = done & (owner_q == OWN_DBG);

  // Read data registers capture only on read completions; writes leave them untouched.
  assign cpu_rdata_d = (cpu_done && !we_q) ? bus.mem_rdata : cpu_rdata_q;
  assign dbg_rdata_d = (dbg_done && !we_q) ? bus.mem_rdata : dbg_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      starve_q    <= 4'd0;
      wait_q      <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Address/data come straight from the latch so they hold their last value while IDLE.
  assign bus.mem_en    = (state_q != ST_IDLE);
  assign bus.mem_we    = (state_q != ST_IDLE) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign cpu_stall     = bus.cpu_req & ~cpu_done;
  assign bus.cpu_stall = cpu_stall;
  assign bus.cpu_rdata = cpu_done ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dbg_rdata = dbg_done ? bus.mem_rdata : dbg_rdata_q;
  assign bus.dbg_ack   = dbg_done;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_grant_q, perf_grant_d;

  assign perf_stall_d = (cpu_stall && !(&perf_stall_q)) ? perf_stall_q + 32'd1 : perf_stall_q;
  assign perf_grant_d = ((state_q == ST_IDLE) && grant_dbg && !(&perf_grant_q)) ?
                        perf_grant_q + 16'd1 : perf_grant_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_grant_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_grant_q <= perf_grant_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_dbg_grants   = perf_grant_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, hand-written corner sequences and a randomized
// two-requester run compared against a transaction-level reference model.
// Memory behind the port is a 64-word RAM (reset to known contents) plus a pattern-based I/O region.
module tb_dmem_arbiter;

  localparam logic [31:0] IO_BASE      = 32'hF0000000;
  localparam int          IO_WAIT      = 2;
  localparam int          STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DBITS(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_dbg;
`endif

  dmem_arbiter #(
    .DBITS(32), .IO_BASE(IO_BASE), .IO_WAIT(IO_WAIT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall),
    .perf_dbg_grants   (perf_dbg)
`endif
  );

  // Memory environment: RAM writes land on the clock edge, reads are combinational.
  logic [31:0] ram [0:63];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h5A000000 | 32'(i);
      ram[16] <= 32'h12345678;
    end else if (bus.mem_en && bus.mem_we && (bus.mem_addr < IO_BASE)) begin
      ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = (bus.mem_addr < IO_BASE) ? ram[bus.mem_addr[7:2]]
                                                  : {bus.mem_addr[15:0], 16'hC0DE};

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a < IO_BASE) ? ram[a[7:2]] : {a[15:0], 16'hC0DE};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_en;
    int          exp_we;
    int          exp_stall;
    int          exp_ack;
    logic [31:0] exp_rd_done;
    logic [31:0] exp_held;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int en = 0, we = 0, st = 0, ack = 0, bad = 0;
    logic [31:0] rdd = '0;
    logic got = 1'b0;
    @(negedge clk);
    if (v.dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = v.we; bus.dbg_addr = v.addr; bus.dbg_wdata = v.wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.mem_en) en++;
      if (bus.mem_we) we++;
      if (bus.cpu_stall) st++;
      if (bus.dbg_ack) ack++;
      if (bus.mem_en && bus.mem_addr !== v.addr) bad++;
      if (v.dbg ? bus.dbg_ack : (bus.mem_en && !bus.cpu_stall)) begin
        got = 1'b1;
        rdd = v.dbg ? bus.dbg_rdata : bus.cpu_rdata;
      end
    end
    chk({v.name, "_done"}, 32'(got), 32'd1);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (bus.mem_en) en++;
      if (bus.mem_we) we++;
      if (bus.cpu_stall) st++;
      if (bus.dbg_ack) ack++;
      @(negedge clk);
    end
    #1;
    chk({v.name, "_mem_en_cycles"}, 32'(en), 32'(v.exp_en));
    chk({v.name, "_mem_we_cycles"}, 32'(we), 32'(v.exp_we));
    chk({v.name, "_stall_cycles"}, 32'(st), 32'(v.exp_stall));
    chk({v.name, "_ack_pulses"}, 32'(ack), 32'(v.exp_ack));
    chk({v.name, "_addr_stable"}, 32'(bad), 32'd0);
    if (!v.we) chk({v.name, "_rdata_done"}, rdd, v.exp_rd_done);
    chk({v.name, "_rdata_held"}, v.dbg ? bus.dbg_rdata : bus.cpu_rdata, v.exp_held);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return IO_BASE + 32'($urandom_range(0, 15)) * 32'd4;
    return 32'($urandom_range(0, 63)) * 32'd4;
  endfunction

  // Reference model: one outstanding access tracked as a count of remaining port cycles.
  task automatic random_phase(input int ncyc);
    int          rem = 0, lost = 0, grants = 0;
    logic        own = 1'b0, lwe = 1'b0, done, gd, gc;
    logic [31:0] laddr = '0, lwdata = '0, crd = '0, drd = '0, mv;
    logic        cpend = 1'b0, dpend = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      if (!cpend) begin
        if ($urandom_range(0, 2) == 0) begin
          cpend = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1));
          bus.cpu_addr = rand_addr(); bus.cpu_wdata = $urandom;
        end else bus.cpu_req = 1'b0;
      end
      if (!dpend) begin
        if ($urandom_range(0, 2) == 0) begin
          dpend = 1'b1; bus.dbg_req = 1'b1; bus.dbg_we = 1'($urandom_range(0, 1));
          bus.dbg_addr = rand_addr(); bus.dbg_wdata = $urandom;
        end else bus.dbg_req = 1'b0;
      end
      #1;
      done = (rem == 1);
      mv   = mem_val(laddr);
      chk("rnd_mem_en", 32'(bus.mem_en), 32'(rem > 0));
      chk("rnd_mem_we", 32'(bus.mem_we), 32'(rem > 0 && lwe));
      chk("rnd_mem_addr", bus.mem_addr, laddr);
      chk("rnd_mem_wdata", bus.mem_wdata, lwdata);
      chk("rnd_cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !(done && !own)));
      chk("rnd_dbg_ack", 32'(bus.dbg_ack), 32'(done && own));
      chk("rnd_cpu_rdata", bus.cpu_rdata, (done && !own) ? mv : crd);
      chk("rnd_dbg_rdata", bus.dbg_rdata, (done && own) ? mv : drd);
      if (rem == 0) begin
        gd = bus.dbg_req && (!bus.cpu_req || lost == STARVE_LIMIT);
        gc = bus.cpu_req && !gd;
        if (gd || gc) begin
          grants++;
          own    = gd;
          lwe    = gd ? bus.dbg_we : bus.cpu_we;
          laddr  = gd ? bus.dbg_addr : bus.cpu_addr;
          lwdata = gd ? bus.dbg_wdata : bus.cpu_wdata;
          rem    = (laddr < IO_BASE || IO_WAIT == 0) ? 1 : 1 + IO_WAIT;
          if (gd) lost = 0;
          else if (bus.dbg_req && lost < STARVE_LIMIT) lost++;
        end
      end else begin
        if (done) begin
          if (!lwe) begin
            if (own) drd = mv;
            else crd = mv;
          end
          if (own) dpend = 1'b0;
          else cpend = 1'b0;
        end
        rem--;
      end
    end
    chk("rnd_activity", 32'(grants > ncyc / 8), 32'd1);
    idle_inputs();
  endtask

  initial begin
    int en, st, ngr;

    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_stall_low", 32'(bus.cpu_stall), 32'd0);
    bus.cpu_req = 1'b1;
    #1 chk("rst_stall_follows_req", 32'(bus.cpu_stall), 32'd1);
    bus.cpu_req = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    chk("rst_perf_stall", perf_stall, 32'd0);
    chk("rst_perf_dbg", 32'(perf_dbg), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //         name        dbg   we    addr          wdata         en we st ack rd_done       held
    vecs[0] = '{"cpu_rd_ram", 1'b0, 1'b0, 32'h00000040, 32'h0,        1, 0, 1, 0, 32'h12345678, 32'h12345678};
    vecs[1] = '{"cpu_wr_io",  1'b0, 1'b1, 32'hF0000004, 32'h000000AA, 3, 3, 3, 0, 32'h0,        32'h12345678};
    vecs[2] = '{"dbg_wr_ram", 1'b1, 1'b1, 32'h00000100, 32'hDEADBEEF, 1, 1, 0, 1, 32'h0,        32'h00000000};
    vecs[3] = '{"dbg_rd_ram", 1'b1, 1'b0, 32'h00000100, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4] = '{"cpu_rd_io",  1'b0, 1'b0, 32'hF0000010, 32'h0,        3, 0, 3, 0, 32'h0010C0DE, 32'h0010C0DE};
    vecs[5] = '{"cpu_wr_ram", 1'b0, 1'b1, 32'h00000040, 32'hCAFEF00D, 1, 1, 1, 0, 32'h0,        32'h0010C0DE};
    vecs[6] = '{"cpu_rd_back",1'b0, 1'b0, 32'h00000040, 32'h0,        1, 0, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[7] = '{"dbg_rd_io",  1'b1, 1'b0, 32'hF0000020, 32'h0,        3, 0, 0, 1, 32'h0020C0DE, 32'h0020C0DE};
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters held continuously: CPU,CPU,CPU,CPU,DBG repeating.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h00000040;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h00000080;
    st = 0; ngr = 0;
    for (int cyc = 0; cyc < 100 && ngr < 10; cyc++) begin
      #1;
      if (bus.cpu_stall) st++;
      if (bus.dbg_ack) begin
        chk("starve_grant_seq", 32'd1, 32'(ngr % 5 == 4));
        ngr++;
      end else if (bus.mem_en && !bus.cpu_stall) begin
        chk("starve_grant_seq", 32'd0, 32'(ngr % 5 == 4));
        ngr++;
      end
      @(negedge clk);
    end
    chk("starve_grant_count", 32'(ngr), 32'd10);
    chk("starve_stall_cycles", 32'(st), 32'd12);
    idle_inputs();
    @(posedge clk);
    #1;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_dbg_grants", 32'(perf_dbg), 32'd2);
    chk("perf_stall_cycles", perf_stall, 32'(st));
`endif

    // Reset asserted in the middle of an I/O write's wait states.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'hF0000004; bus.cpu_wdata = 32'h0000000F;
    repeat (2) @(negedge clk);
    #1;
    chk("iowait_pre_rst_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_stall_follows_req", 32'(bus.cpu_stall), 32'd1);
    bus.cpu_req = 1'b0;
    #1 chk("midrst_stall_low", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.mem_en || bus.mem_we) en++;
      @(negedge clk);
    end
    chk("post_rst_no_access", 32'(en), 32'd0);
    run_vec(vecs[0]);

    do_reset();
    random_phase(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory/MMIO port between two requesters: the CPU memory stage and a debug/loader port.
- Inserts wait states for slow I/O (MMIO) addresses and stalls the pipeline until each access completes.
- Sits between the pipeline register outputs (memory stage) and DataMemory.

Parameters:
- DBITS, 32, data and address width.
- IO_BASE, 32'hF0000000, addresses >= IO_BASE are I/O region.
- IO_WAIT, 2, extra cycles an I/O access is held (0..15).
- STARVE_LIMIT, 4, consecutive lost IDLE arbitrations before debug is forced a grant (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  CPU memory-stage access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  DBITS  CPU byte address.
- cpu_wdata  in  DBITS  CPU store data.
- cpu_rdata  out  DBITS  CPU load data.
- cpu_stall  out  1  freeze fetch/decode and pipeline split while high.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write (1) / read (0).
- dbg_addr  in  DBITS  debug address.
- dbg_wdata  in  DBITS  debug store data.
- dbg_rdata  out  DBITS  debug load data.
- dbg_ack  out  1  one-cycle completion pulse to debug.
- mem_en  out  1  memory port active.
- mem_we  out  1  memory write enable.
- mem_addr  out  DBITS  memory address.
- mem_wdata  out  DBITS  memory write data.
- mem_rdata  in  DBITS  memory read data, combinational from mem_addr.

Behaviour:
- FSM states: IDLE, ACCESS, IOWAIT. Owner register: CPU or DBG.
- IDLE arbitration, every cycle:
  - Grant CPU if cpu_req, unless dbg_req and starve_cnt == STARVE_LIMIT, in which case grant DBG.
  - Otherwise grant DBG if dbg_req.
  - On grant: latch we/addr/wdata of the winner; go to ACCESS.
- starve_cnt:
  - Increments when both requesters are active in IDLE and CPU wins.
  - Clears on any DBG grant.
  - Saturates at STARVE_LIMIT.
- ACCESS:
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the latched request.
  - If the latched address < IO_BASE, or IO_WAIT == 0: completes this cycle, next state IDLE.
  - Otherwise load wait_cnt = IO_WAIT and go to IOWAIT.
- IOWAIT:
  - mem_* held unchanged; wait_cnt decrements each cycle.
  - Completes in the cycle wait_cnt == 1, then next state IDLE.
- Completion cycle ("done"):
  - Owner CPU: cpu_done = 1, cpu_rdata = mem_rdata (pass-through), and the rdata register captures it.
  - Owner DBG: dbg_ack = 1, dbg_rdata = mem_rdata, registered likewise.
  - Outside done, cpu_rdata/dbg_rdata show their held registers.
  - Write accesses leave the rdata registers unchanged.
- cpu_stall = cpu_req & ~cpu_done (combinational).
- Latency:
  - RAM access: 2 cycles, request seen in IDLE at t, done at t+1.
  - I/O access: 2+IO_WAIT cycles.
  - A return to IDLE is mandatory between accesses, so back-to-back RAM throughput is one access per 2 cycles.
- Requesters hold req/we/addr/wdata stable until done/ack. Once granted, an access always completes, even if req drops; a late done with cpu_req low produces no stall effect.
- A debug request arriving while the CPU owns the port waits. The CPU then re-arbitrates against it in IDLE.
- Outside ACCESS/IOWAIT: mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold their last value.
- Reset, asynchronous and active at any time including mid-access:
  - State IDLE, owner CPU, starve_cnt = 0, wait_cnt = 0.
  - mem_en/mem_we/dbg_ack = 0; mem_addr/mem_wdata/cpu_rdata/dbg_rdata = 0.
  - cpu_stall follows cpu_req.
  - The interrupted access is discarded; no write is issued after reset.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles[31:0], counting cycles with cpu_stall = 1.
  - Adds output perf_dbg_grants[15:0], counting DBG grants.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- CPU read, addr 0x00000040, mem_rdata = 0x12345678 -> cpu_stall high 1 cycle, mem_en high 1 cycle, cpu_rdata = 0x12345678 in done cycle and held afterwards.
- CPU write to 0xF0000004 (LEDR), IO_WAIT = 2 -> mem_en/mem_we high 3 consecutive cycles with addr 0xF0000004 stable; cpu_stall high 3 cycles total.
- cpu_req and dbg_req held continuously, STARVE_LIMIT = 4 -> grant sequence CPU,CPU,CPU,CPU,DBG repeating; dbg_ack exactly one pulse per 5 grants.
- dbg_req only, write 0xDEADBEEF to 0x00000100 -> mem_we for 1 cycle, one dbg_ack pulse, cpu_stall stays low, dbg_rdata unchanged.
- reset driven low during IOWAIT of a CPU write -> mem_en/mem_we drop immediately; after release FSM is IDLE and no write pulse appears without a new request.
- With DMEM_ARB_PERF_EN, run scenario 3 for 10 grants -> perf_dbg_grants = 2; perf_stall_cycles equals the count of cpu_stall-high cycles.
